tmds_rx_decoder: RTL and testbench

TMDS_RX_DECODER -- requirements
Module: tmds_rx_decoder

---
 rtl/tmds_rx_decoder.sv | 189 ++++++++++++++++++
 tb/tb_tmds_rx_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_rx_decoder.sv
// TMDS receive decoder: token/data decode, SEARCH/LOCKED word alignment with bitslip, raster position recovery.
// Optional build macro TMDS_RX_ERRCNT_EN enables the saturating symbol-error counter on err_count.
module tmds_rx_decoder #(
    parameter int H_ACTIVE = 1280,
    parameter int CTRL_RUN = 8,
    parameter int TIMEOUT  = 4096
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic [9:0]         tmds_sym [0:2],
    output logic [7:0]         pixel    [0:2],
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               fsync,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               locked,
    output logic               bitslip,
    output logic               sym_err,
    output logic [15:0]        err_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(CTRL_RUN + 1);
    localparam logic signed [11:0] POS_MAX = 12'sd2047;

    if (H_ACTIVE < 1 || H_ACTIVE > 2048 || CTRL_RUN < 1 || TIMEOUT < 2) begin : g_param_check
        $error("tmds_rx_decoder: parameter out of range");
    end

    typedef enum logic {SEARCH, LOCKED} state_t;

    function automatic logic is_token(input logic [9:0] q);
        return (q == 10'b1101010100) || (q == 10'b0010101011) ||
               (q == 10'b0101010100) || (q == 10'b1010101011);
    endfunction

    function automatic logic [1:0] token_ctrl(input logic [9:0] q);
        case (q)
            10'b0010101011: return 2'b01;
            10'b0101010100: return 2'b10;
            10'b1010101011: return 2'b11;
            default:        return 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] decode_data(input logic [9:0] q);
        logic [7:0] qm;
        logic [7:0] d;
        qm   = q[9] ? ~q[7:0] : q[7:0];
        d[0] = qm[0];
        for (int unsigned i = 1; i < 8; i++)
            d[i] = q[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
        return d;
    endfunction

    logic [2:0] in_tok;
    logic [1:0] in_ctrl;
    logic [7:0] in_data [0:2];

    always_comb begin
        for (int unsigned ch = 0; ch < 3; ch++) begin
            in_tok[ch]  = is_token(tmds_sym[ch]);
            in_data[ch] = decode_data(tmds_sym[ch]);
        end
        in_ctrl = token_ctrl(tmds_sym[0]);
    end

    // Alignment FSM
    state_t        state, state_nx;
    logic [TW-1:0] idle_cnt, idle_cnt_nx;
    logic [RW-1:0] run_cnt, run_cnt_nx;
    logic          bitslip_nx;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state    <= SEARCH;
            idle_cnt <= '0;
            run_cnt  <= '0;
            bitslip  <= 1'b0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_cnt_nx;
            run_cnt  <= run_cnt_nx;
            bitslip  <= bitslip_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idle_cnt_nx = idle_cnt;
        run_cnt_nx  = run_cnt;
        bitslip_nx  = 1'b0;
        if (in_tok[0]) begin
            idle_cnt_nx = '0;
            if (state == SEARCH) begin
                if (run_cnt == RW'(CTRL_RUN - 1)) begin
                    state_nx   = LOCKED;
                    run_cnt_nx = '0;
                end else begin
                    run_cnt_nx = run_cnt + 1'b1;
                end
            end
        end else begin
            run_cnt_nx = '0;
            if (idle_cnt == TW'(TIMEOUT - 1)) begin
                idle_cnt_nx = '0;
                if (state == SEARCH) bitslip_nx = 1'b1;
                else                 state_nx   = SEARCH;
            end else begin
                idle_cnt_nx = idle_cnt + 1'b1;
            end
        end
    end

    assign locked = (state == LOCKED);

    // Stage 1: registered decode; syncs latch on channel-0 tokens and hold through data
    logic [2:0] s1_tok;
    logic [7:0] s1_pix [0:2];
    logic       s1_hs, s1_vs;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            s1_tok <= '0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            for (int unsigned ch = 0; ch < 3; ch++) s1_pix[ch] <= '0;
        end else begin
            s1_tok <= in_tok;
            for (int unsigned ch = 0; ch < 3; ch++) s1_pix[ch] <= in_data[ch];
            if (in_tok[0]) {s1_vs, s1_hs} <= in_ctrl;
        end
    end

    // Stage 2: lock state here already includes the symbol now in stage 1
    logic act_nx, act_rise, vs_rise, err_nx, v_pend;

    always_comb begin
        act_nx   = locked && !s1_tok[0];
        act_rise = act_nx && !active;
        vs_rise  = s1_vs && !vsync;
        err_nx   = locked && (s1_tok[0] ? !(s1_tok[1] && s1_tok[2]) : (s1_tok[1] || s1_tok[2]));
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            active  <= 1'b0;
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            fsync   <= 1'b0;
            sym_err <= 1'b0;
            hpos    <= '0;
            vpos    <= '0;
            v_pend  <= 1'b0;
            for (int unsigned ch = 0; ch < 3; ch++) pixel[ch] <= '0;
        end else begin
            active  <= act_nx;
            hsync   <= s1_hs;
            vsync   <= s1_vs;
            fsync   <= vs_rise && locked;
            sym_err <= err_nx;
            for (int unsigned ch = 0; ch < 3; ch++) pixel[ch] <= act_nx ? s1_pix[ch] : '0;
            if (vs_rise) v_pend <= 1'b1;
            // A pending vsync is consumed by the next line start, including one in the same cycle
            if (act_rise) begin
                hpos <= '0;
                if (v_pend || vs_rise) begin
                    vpos   <= '0;
                    v_pend <= 1'b0;
                end else if (vpos != POS_MAX) begin
                    vpos <= vpos + 12'sd1;
                end
            end else if (act_nx && hpos != POS_MAX) begin
                hpos <= hpos + 12'sd1;
            end
        end
    end

`ifdef TMDS_RX_ERRCNT_EN
    always_ff @(posedge pixel_clk) begin
        if (!rst_n)                          err_count <= '0;
        else if (err_nx && err_count != '1)  err_count <= err_count + 16'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Randomized self-checking bench for tmds_rx_decoder against a symbol-level reference model.
module tb_tmds_rx_decoder;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int CTRL_RUN = 8;
    localparam int TIMEOUT  = 4096;

    logic               pixel_clk = 1'b0;
    logic               rst_n;
    logic [9:0]         sym [0:2];
    logic [7:0]         pix [0:2];
    logic               active, hsync, vsync, fsync, locked, bitslip, sym_err;
    logic signed [11:0] hpos, vpos;
    logic [15:0]        err_count;

    tmds_rx_decoder #(.H_ACTIVE(1280), .CTRL_RUN(CTRL_RUN), .TIMEOUT(TIMEOUT)) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .tmds_sym(sym), .pixel(pix),
        .active(active), .hsync(hsync), .vsync(vsync), .fsync(fsync),
        .hpos(hpos), .vpos(vpos), .locked(locked), .bitslip(bitslip),
        .sym_err(sym_err), .err_count(err_count)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Control tokens indexed by their {C1,C0} value
    logic [9:0] tok_tab [0:3] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    typedef struct {
        logic [7:0] pb, pg, pr;
        logic       act, hs, vs, fs, err;
        int         hp, vp, ec;
    } rec_t;

    rec_t exp_q [$];
    logic m_locked, m_slip, m_hs, m_vs, m_prev_act, m_prev_vs, m_pend;
    int   m_run, m_idle, m_hp, m_vp, m_ec;

    function automatic int tok_idx(input logic [9:0] q);
        for (int i = 0; i < 4; i++) if (q == tok_tab[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] q);
        logic [7:0] qm, x;
        qm = q[9] ? ~q[7:0] : q[7:0];
        x  = qm ^ {qm[6:0], 1'b0};
        return q[8] ? x : (x ^ 8'hFE);
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 2047) ? 2047 : v + 1;
    endfunction

    task automatic model_reset();
        rec_t z;
        m_locked = 0; m_slip = 0; m_hs = 0; m_vs = 0;
        m_prev_act = 0; m_prev_vs = 0; m_pend = 0;
        m_run = 0; m_idle = 0; m_hp = 0; m_vp = 0; m_ec = 0;
        z = '{pb: 0, pg: 0, pr: 0, act: 0, hs: 0, vs: 0, fs: 0, err: 0, hp: 0, vp: 0, ec: 0};
        exp_q.delete();
        exp_q.push_back(z);
    endtask

    task automatic model_step(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r);
        rec_t rc;
        int t0, t1, t2;
        logic vs_rise;
        logic [1:0] cb;
        t0 = tok_idx(b); t1 = tok_idx(g); t2 = tok_idx(r);
        m_slip = 0;
        if (t0 >= 0) begin
            m_idle = 0;
            if (!m_locked) begin
                m_run++;
                if (m_run == CTRL_RUN) begin m_locked = 1; m_run = 0; end
            end
            cb = 2'(t0);
            m_hs = cb[0]; m_vs = cb[1];
        end else begin
            m_run = 0;
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_idle = 0;
                if (m_locked) m_locked = 0; else m_slip = 1;
            end
        end
        rc.act  = m_locked && (t0 < 0);
        vs_rise = m_vs && !m_prev_vs;
        rc.fs   = vs_rise && m_locked;
        rc.err  = m_locked && ((t0 >= 0) ? !(t1 >= 0 && t2 >= 0) : (t1 >= 0 || t2 >= 0));
        if (vs_rise) m_pend = 1;
        if (rc.act && !m_prev_act) begin
            m_hp = 0;
            if (m_pend) begin m_vp = 0; m_pend = 0; end
            else m_vp = sat_inc(m_vp);
        end else if (rc.act) begin
            m_hp = sat_inc(m_hp);
        end
`ifdef TMDS_RX_ERRCNT_EN
        if (rc.err && m_ec < 65535) m_ec++;
`endif
        rc.pb = rc.act ? ref_decode(b) : 8'h00;
        rc.pg = rc.act ? ref_decode(g) : 8'h00;
        rc.pr = rc.act ? ref_decode(r) : 8'h00;
        rc.hs = m_hs; rc.vs = m_vs;
        rc.hp = m_hp; rc.vp = m_vp; rc.ec = m_ec;
        m_prev_act = rc.act;
        m_prev_vs  = m_vs;
        exp_q.push_back(rc);
    endtask

    task automatic compare_outputs(input rec_t e);
        check("pixel_b", pix[0], e.pb);
        check("pixel_g", pix[1], e.pg);
        check("pixel_r", pix[2], e.pr);
        check("active", active, e.act);
        check("hsync", hsync, e.hs);
        check("vsync", vsync, e.vs);
        check("fsync", fsync, e.fs);
        check("sym_err", sym_err, e.err);
        check("hpos", hpos, e.hp);
        check("vpos", vpos, e.vp);
        check("err_count", err_count, e.ec);
    endtask

    task automatic step(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r);
        sym[0] = b; sym[1] = g; sym[2] = r;
        @(posedge pixel_clk); #1;
        model_step(b, g, r);
        check("locked", locked, m_locked);
        check("bitslip", bitslip, m_slip);
        compare_outputs(exp_q.pop_front());
    endtask

    task automatic reset_step();
        rec_t z;
        rst_n = 1'b0;
        sym[0] = 10'($urandom); sym[1] = 10'($urandom); sym[2] = 10'($urandom);
        @(posedge pixel_clk); #1;
        z = '{pb: 0, pg: 0, pr: 0, act: 0, hs: 0, vs: 0, fs: 0, err: 0, hp: 0, vp: 0, ec: 0};
        check("rst_locked", locked, 0);
        check("rst_bitslip", bitslip, 0);
        compare_outputs(z);
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] q;
        do q = 10'($urandom); while (tok_idx(q) >= 0);
        return q;
    endfunction

    // Side channels mostly follow channel 0's kind, occasionally disagree
    function automatic logic [9:0] rand_side(input logic want_tok);
        logic t;
        t = ($urandom_range(15) == 0) ? !want_tok : want_tok;
        return t ? tok_tab[$urandom_range(3)] : rand_data();
    endfunction

    task automatic step_ctl(input int idx);
        step(tok_tab[idx], rand_side(1'b1), rand_side(1'b1));
    endtask

    task automatic step_dat();
        step(rand_data(), rand_side(1'b0), rand_side(1'b0));
    endtask

    task automatic send_line(input int len, input logic vs_on);
        for (int i = 0; i < 3; i++) step_ctl(vs_on ? 3 : 1);
        for (int i = 0; i < 3; i++) step_ctl(vs_on ? 2 : 0);
        for (int i = 0; i < len; i++) step_dat();
    endtask

    task automatic send_frame(input int lines);
        send_line(0, 1'b1);
        send_line($urandom_range(3), 1'b1);
        for (int l = 0; l < lines; l++) send_line($urandom_range(40, 1), 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int slips;
        rst_n = 1'b0;
        sym[0] = '0; sym[1] = '0; sym[2] = '0;
        model_reset();
        repeat (3) reset_step();

        // Seven tokens are one short of lock; eight lock on the cycle after the last
        repeat (7) step(tok_tab[0], tok_tab[0], tok_tab[0]);
        step(rand_data(), rand_data(), rand_data());
        check("nolock_after_7", locked, 0);
        repeat (8) step(tok_tab[0], tok_tab[0], tok_tab[0]);
        check("lock_after_8", locked, 1);

        step(10'b0100000000, rand_data(), rand_data());
        step(rand_data(), rand_data(), rand_data());
        check("zero_pixel_b", pix[0], 0);
        check("zero_pixel_active", active, 1);
        check("zero_pixel_hpos", hpos, 0);

        repeat (6) send_frame($urandom_range(12, 4));

        // Vsync rising edge, then the first line after it
        repeat (6) step_ctl(0);
        step_ctl(2);
        step_ctl(2);
        check("vs_high", vsync, 1);
        check("fsync_pulse", fsync, 1);
        step_ctl(0);
        check("fsync_single", fsync, 0);
        step_dat();
        step_dat();
        check("first_line_vpos", vpos, 0);
        check("first_line_hpos", hpos, 0);

        step(tok_tab[0], rand_data(), tok_tab[0]);
        step(tok_tab[0], tok_tab[0], tok_tab[0]);
        check("mismatch_sym_err", sym_err, 1);
        step(tok_tab[0], tok_tab[0], tok_tab[0]);

        // Long data run: hpos saturates, lock drops without bitslip, then search times out once
        repeat (TIMEOUT) step_dat();
        check("unlock_after_timeout", locked, 0);
        check("hpos_saturated", hpos, 2047);
        slips = 0;
        repeat (TIMEOUT) begin
            step_dat();
            slips += int'(bitslip);
        end
        check("slip_count", slips, 1);

        repeat (10) step_ctl(0);
        check("relock", locked, 1);
        repeat (2050) begin
            step_ctl(0);
            step_dat();
        end
        step_ctl(0);
        check("vpos_saturated", vpos, 2047);

        send_frame(3);
        repeat (4) step_ctl(0);
        repeat (502) step_dat();
        check("hpos_500", hpos, 500);
        reset_step();
        repeat (4) step_dat();
        repeat (10) step_ctl(0);
        send_frame(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
